// File: rtl/apb_regfile_slave.sv
`default_nettype none
// ============================================================================
// Module : apb_regfile_slave
// Brief  : APB3 completer with NUM_REGS RW registers, a read-only write counter
//          and programmable wait states. Build macro APB_REGFILE_SLVERR_EN
//          enables the pslverr error response (tied low otherwise).
// Rev    : 1.0
// ============================================================================
module apb_regfile_slave #(
    parameter int          NUM_REGS    = 8,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_A000,
    parameter int          WAIT_STATES = 1
) (
    input  logic        pclk,
    input  logic        preset_n,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] paddr,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr
);

    localparam int              L         = $clog2(NUM_REGS);
    localparam int              IDXW      = L + 1;
    localparam logic [IDXW-1:0] CNT_IDX   = IDXW'(NUM_REGS);
    localparam logic [3:0]      WAIT_INIT = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_READY = 2'd2
    } state_t;

    state_t      state_q;
    logic [31:0] regs_q [NUM_REGS];
    logic [31:0] wr_count_q;
    logic [3:0]  wcnt_q;
    logic        write_q;
    logic        reg_hit_q;
    logic        cnt_hit_q;
    logic [L-1:0] ridx_q;
    logic        pready_q;
    logic [31:0] prdata_q;

    logic [IDXW-1:0] addr_idx;
    logic            addr_in_win;
    logic            addr_aligned;
    logic            addr_reg;
    logic            addr_cnt;
    logic            setup;
    logic            go_ready;

    assign addr_idx     = paddr[L+2:2];
    assign addr_in_win  = (paddr[31:L+3] == BASE_ADDR[31:L+3]);
    assign addr_aligned = (paddr[1:0] == 2'b00);
    assign addr_reg     = addr_in_win && addr_aligned && (addr_idx < CNT_IDX);
    assign addr_cnt     = addr_in_win && addr_aligned && (addr_idx == CNT_IDX);
    assign setup        = psel && !penable;

    // With zero wait states READY is entered straight from the setup edge, so
    // the response is built from the live decode there and from the latched one otherwise.
    logic         src_write;
    logic         src_reg;
    logic         src_cnt;
    logic [L-1:0] src_idx;
    logic [31:0]  rd_value;

    always_comb begin
        src_write = write_q;
        src_reg   = reg_hit_q;
        src_cnt   = cnt_hit_q;
        src_idx   = ridx_q;
        if (state_q == S_IDLE) begin
            src_write = pwrite;
            src_reg   = addr_reg;
            src_cnt   = addr_cnt;
            src_idx   = addr_idx[L-1:0];
        end
    end

    always_comb begin
        rd_value = 32'h0;
        if (!src_write) begin
            if (src_reg) begin
                rd_value = regs_q[src_idx];
            end else if (src_cnt) begin
                rd_value = wr_count_q;
            end
        end
    end

    assign go_ready = ((state_q == S_IDLE) && setup && (WAIT_STATES == 0)) ||
                      ((state_q == S_WAIT) && psel && (wcnt_q == 4'd1));

`ifdef APB_REGFILE_SLVERR_EN
    logic src_err;
    logic pslverr_q;
    assign src_err = !(src_reg || src_cnt) || (src_write && src_cnt);
    assign pslverr = pslverr_q;
`else
    assign pslverr = 1'b0;
`endif

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state_q    <= S_IDLE;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= 32'h0;
            end
            wr_count_q <= 32'h0;
            wcnt_q     <= 4'd0;
            write_q    <= 1'b0;
            reg_hit_q  <= 1'b0;
            cnt_hit_q  <= 1'b0;
            ridx_q     <= '0;
            pready_q   <= 1'b0;
            prdata_q   <= 32'h0;
`ifdef APB_REGFILE_SLVERR_EN
            pslverr_q  <= 1'b0;
`endif
        end else begin
            pready_q  <= go_ready;
            prdata_q  <= go_ready ? rd_value : 32'h0;
`ifdef APB_REGFILE_SLVERR_EN
            pslverr_q <= go_ready && src_err;
`endif
            case (state_q)
                S_IDLE: begin
                    if (setup) begin
                        write_q   <= pwrite;
                        reg_hit_q <= addr_reg;
                        cnt_hit_q <= addr_cnt;
                        ridx_q    <= addr_idx[L-1:0];
                        wcnt_q    <= WAIT_INIT;
                        state_q   <= (WAIT_STATES == 0) ? S_READY : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!psel) begin
                        state_q <= S_IDLE;
                    end else begin
                        wcnt_q <= wcnt_q - 4'd1;
                        if (wcnt_q == 4'd1) begin
                            state_q <= S_READY;
                        end
                    end
                end
                S_READY: begin
                    state_q <= S_IDLE;
                    // Only a RW-register hit can write; every error case fails this test.
                    if (psel && write_q && reg_hit_q) begin
                        regs_q[ridx_q] <= pwdata;
                        wr_count_q     <= wr_count_q + 32'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign pready = pready_q;
    assign prdata = prdata_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_regfile_slave.sv
`default_nettype none
// ============================================================================
// Module : tb_apb_regfile_slave
// Brief  : Scoreboard bench for apb_regfile_slave; three instances with 0, 1
//          and 3 wait states share one APB bus, psel steered by dut_sel.
// Rev    : 1.0
// ============================================================================
module tb_apb_regfile_slave;

`ifdef APB_REGFILE_SLVERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        pclk    = 1'b0;
    logic        por_n   = 1'b0;
    logic        rst_req = 1'b0;
    logic        psel    = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite  = 1'b0;
    logic [31:0] paddr   = 32'h0;
    logic [31:0] pwdata  = 32'h0;
    int          dut_sel = 1;
    int          cyc     = 0;
    int          checks  = 0;
    int          failures = 0;

    logic [2:0]  psel_v;
    logic [2:0]  rstn_v;
    logic [31:0] prdata_v [3];
    logic [2:0]  pready_v;
    logic [2:0]  pslverr_v;
    logic [31:0] m_prdata;
    logic        m_pready;
    logic        m_pslverr;

    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc = cyc + 1;

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            psel_v[k] = psel && (dut_sel == k);
            rstn_v[k] = por_n && !(rst_req && (dut_sel == k));
        end
        m_prdata  = prdata_v[dut_sel];
        m_pready  = pready_v[dut_sel];
        m_pslverr = pslverr_v[dut_sel];
    end

    apb_regfile_slave #(.NUM_REGS(8), .BASE_ADDR(32'h0000_A000), .WAIT_STATES(0)) u_dut0 (
        .pclk(pclk), .preset_n(rstn_v[0]), .psel(psel_v[0]), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata_v[0]), .pready(pready_v[0]), .pslverr(pslverr_v[0]));

    apb_regfile_slave #(.NUM_REGS(8), .BASE_ADDR(32'h0000_A000), .WAIT_STATES(1)) u_dut1 (
        .pclk(pclk), .preset_n(rstn_v[1]), .psel(psel_v[1]), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata_v[1]), .pready(pready_v[1]), .pslverr(pslverr_v[1]));

    apb_regfile_slave #(.NUM_REGS(8), .BASE_ADDR(32'h0000_A000), .WAIT_STATES(3)) u_dut2 (
        .pclk(pclk), .preset_n(rstn_v[2]), .psel(psel_v[2]), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata_v[2]), .pready(pready_v[2]), .pslverr(pslverr_v[2]));

    typedef struct {
        string       tag;
        int          cyc;
        bit          chk_rd;
        logic [31:0] rd;
        bit          err;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    exp_t drv_e;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: pops one expectation per pready pulse; idle cycles must be quiet.
    always @(negedge pclk) begin
        if (m_pready) begin
            if (sbq.size() == 0) begin
                checks = checks + 1;
                failures = failures + 1;
                $display("FAIL spurious_pready: got pready=1 expected 0 (cycle %0d)", cyc);
            end else begin
                mon_e = sbq.pop_front();
                chk({mon_e.tag, "_latency"}, 32'(cyc), 32'(mon_e.cyc));
                chk({mon_e.tag, "_pslverr"}, {31'h0, m_pslverr}, {31'h0, mon_e.err});
                if (mon_e.chk_rd) chk({mon_e.tag, "_prdata"}, m_prdata, mon_e.rd);
            end
        end else if (por_n) begin
            chk("idle_outputs", {m_prdata[30:0], m_pslverr}, 32'h0);
        end
    end

    function automatic int ws_of(input int s);
        return (s == 0) ? 0 : ((s == 1) ? 1 : 3);
    endfunction

    // For a read, 'data' is the expected prdata; pwrite/paddr are scrambled during access.
    task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                        input bit err, input string tag);
        bit seen;
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr;
        pwdata = wr ? data : 32'h0;
        drv_e.tag = tag; drv_e.cyc = cyc + 1 + ws_of(dut_sel);
        drv_e.chk_rd = !wr; drv_e.rd = wr ? 32'h0 : data; drv_e.err = err && ERR_EN;
        sbq.push_back(drv_e);
        @(posedge pclk); #1;
        penable = 1'b1; pwrite = !wr; paddr = 32'hFFFF_FFFC;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge pclk);
            if (m_pready) seen = 1'b1;
        end
        if (!seen) begin
            checks = checks + 1;
            failures = failures + 1;
            $display("FAIL %s_timeout: got no pready expected pready within 40 cycles", tag);
        end
    endtask

    task automatic bus_idle(input int n);
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0;
        repeat (n) @(posedge pclk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000 time units");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        por_n = 1'b1;
        @(negedge pclk);
        for (int k = 0; k < 3; k++) begin
            chk("reset_pready", {31'h0, pready_v[k]}, 32'h0);
            chk("reset_prdata", prdata_v[k], 32'h0);
            chk("reset_pslverr", {31'h0, pslverr_v[k]}, 32'h0);
        end

        // WS=1 instance: reset contents, basic write/read, errors
        dut_sel = 1;
        for (int i = 0; i <= 8; i++) xfer(1'b0, 32'hA000 + 32'(4 * i), 32'h0, 1'b0, "rst_read");
        xfer(1'b1, 32'hA004, 32'hDEAD_BEEF, 1'b0, "wr_a004");
        xfer(1'b0, 32'hA004, 32'hDEAD_BEEF, 1'b0, "rd_a004");
        xfer(1'b0, 32'hA020, 32'd1, 1'b0, "rd_cnt1");
        xfer(1'b1, 32'hA020, 32'h5, 1'b1, "wr_cnt_err");
        xfer(1'b0, 32'hA020, 32'd1, 1'b0, "rd_cnt_after_err");
        xfer(1'b0, 32'hB000, 32'h0, 1'b1, "rd_miss");
        xfer(1'b0, 32'hA024, 32'h0, 1'b1, "rd_idx9_miss");
        xfer(1'b1, 32'hA002, 32'h55, 1'b1, "wr_misaligned");
        xfer(1'b0, 32'hA000, 32'h0, 1'b0, "rd_a000_unchanged");
        xfer(1'b0, 32'hA004, 32'hDEAD_BEEF, 1'b0, "rd_a004_unchanged");
        xfer(1'b0, 32'hA020, 32'd1, 1'b0, "rd_cnt_still1");
        bus_idle(2);

        // WS=0 instance: back-to-back writes and reads
        dut_sel = 0;
        for (int i = 0; i < 8; i++) xfer(1'b1, 32'hA000 + 32'(4 * i), 32'(i), 1'b0, "ws0_wr");
        for (int i = 0; i < 8; i++) xfer(1'b0, 32'hA000 + 32'(4 * i), 32'(i), 1'b0, "ws0_rd");
        xfer(1'b0, 32'hA020, 32'd8, 1'b0, "ws0_cnt8");
        bus_idle(2);

        // WS=3 instance: abort in the 2nd access cycle
        dut_sel = 2;
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'hA008; pwdata = 32'h1234;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0;
        repeat (6) @(posedge pclk);
        xfer(1'b0, 32'hA008, 32'h0, 1'b0, "abort_rd_a008");
        xfer(1'b0, 32'hA020, 32'h0, 1'b0, "abort_cnt0");
        xfer(1'b1, 32'hA00C, 32'h77, 1'b0, "post_abort_wr");
        xfer(1'b0, 32'hA00C, 32'h77, 1'b0, "post_abort_rd");
        xfer(1'b0, 32'hA020, 32'd1, 1'b0, "post_abort_cnt1");
        bus_idle(1);

        // WS=3 instance: reset asserted during WAIT of a write
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'hA010; pwdata = 32'hAA;
        @(posedge pclk); #1;
        penable = 1'b1;
        #3 rst_req = 1'b1;
        #1;
        chk("midwait_rst_pready", {31'h0, m_pready}, 32'h0);
        chk("midwait_rst_prdata", m_prdata, 32'h0);
        chk("midwait_rst_pslverr", {31'h0, m_pslverr}, 32'h0);
        psel = 1'b0; penable = 1'b0;
        repeat (2) @(negedge pclk);
        rst_req = 1'b0;
        for (int i = 0; i <= 8; i++) xfer(1'b0, 32'hA000 + 32'(4 * i), 32'h0, 1'b0, "post_rst_rd");
        bus_idle(1);

        // WS=1 instance: penable high while idle must not start a transfer
        dut_sel = 1;
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 32'hA004; pwdata = 32'h0BAD;
        repeat (3) @(posedge pclk);
        #1 psel = 1'b0; penable = 1'b0;
        xfer(1'b0, 32'hA004, 32'hDEAD_BEEF, 1'b0, "violation_rd_a004");
        xfer(1'b0, 32'hA020, 32'd1, 1'b0, "violation_cnt1");
        bus_idle(1);

        // WS=1 instance: reset asserted while pready is high
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'hA004;
        drv_e.tag = "rdy_rst_rd"; drv_e.cyc = cyc + 2; drv_e.chk_rd = 1'b1;
        drv_e.rd = 32'hDEAD_BEEF; drv_e.err = 1'b0;
        sbq.push_back(drv_e);
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk);
        @(negedge pclk); #1;
        rst_req = 1'b1;
        #1;
        chk("ready_rst_pready", {31'h0, m_pready}, 32'h0);
        chk("ready_rst_prdata", m_prdata, 32'h0);
        psel = 1'b0; penable = 1'b0;
        repeat (2) @(negedge pclk);
        rst_req = 1'b0;
        xfer(1'b0, 32'hA004, 32'h0, 1'b0, "post_rst_a004");
        xfer(1'b0, 32'hA020, 32'h0, 1'b0, "post_rst_cnt");
        bus_idle(3);

        chk("scoreboard_empty", 32'(sbq.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
